// File: rtl/tdpram32_bus_slave.sv
// -----------------------------------------------------------------------------
// tdpram32_bus_slave
//
// Command-driven slave for the 32-bit port (port B) of the dual-width RAM.
// It accepts single-beat writes and incrementing read bursts, and it inserts
// WAIT_STATES idle cycles before every RAM access beat. Read data comes back on
// the rsp_* channel, which has no backpressure.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cmd_valid       command present
//   cmd_ready       high only while IDLE
//   cmd_we          1 = single-beat write, 0 = read burst
//   cmd_be          write byte enables (ignored for reads)
//   cmd_addr        32-bit word address of the first beat
//   cmd_wdata       write data
//   cmd_burst_len   read beats minus one (ignored for writes)
//   rsp_valid       rsp_rdata is valid this cycle
//   rsp_rdata       read data
//   rsp_last        marks the final beat of a burst
//   ram_we/ram_rd   RAM port-B write/read strobes
//   ram_byte_en     RAM byte enables (zero except during a write strobe)
//   ram_addr        RAM word address
//   ram_wdata       RAM write data
//   ram_rdata       RAM read data, valid the cycle after ram_rd
//   dbg_state       current FSM state (IDLE=0, WAIT=1, ISSUE=2, DRAIN=3)
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high. The master holds the command stable until then.
// The response channel has no ready; every rsp_valid beat must be consumed.
//
// All outputs come from flops. The RAM strobes are loaded on the edge that
// enters ISSUE, so they are high exactly while the FSM sits in ISSUE.
// -----------------------------------------------------------------------------
module tdpram32_bus_slave #(
   parameter int ADDR_WIDTH  = 13,
   parameter int WAIT_STATES = 0,
   parameter int BURST_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [3:0]            cmd_be,
   input  logic [ADDR_WIDTH:0]   cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [BURST_W-1:0]    cmd_burst_len,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_last,
   output logic                  ram_we,
   output logic                  ram_rd,
   output logic [3:0]            ram_byte_en,
   output logic [ADDR_WIDTH:0]   ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [3:0]            WAIT_LD  = 4'(WAIT_STATES);
   localparam bit                    NO_WAIT  = (WAIT_STATES == 0);
   localparam logic [ADDR_WIDTH:0]   ADDR_ONE = 1;
   localparam logic [BURST_W-1:0]    BEAT_ONE = 1;

   state_t               state;
   logic                 we_q;       // latched command direction
   logic [3:0]           be_q;       // latched write byte enables
   logic [BURST_W-1:0]   beat_cnt;   // beats remaining after the current one
   logic [3:0]           wait_cnt;   // wait cycles left before the next beat
   logic                 rd_d1;      // ram_rd delayed: ram_rdata valid now
   logic                 last_d1;    // the read in flight is the final beat

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cmd_ready   <= 1'b1;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         beat_cnt    <= '0;
         wait_cnt    <= 4'd0;
         ram_we      <= 1'b0;
         ram_rd      <= 1'b0;
         ram_byte_en <= 4'd0;
         ram_addr    <= '0;
         ram_wdata   <= 32'd0;
         rd_d1       <= 1'b0;
         last_d1     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_last    <= 1'b0;
         rsp_rdata   <= 32'd0;
      end else begin
         // Strobes are single-cycle unless a transition below re-arms them.
         ram_we      <= 1'b0;
         ram_rd      <= 1'b0;
         ram_byte_en <= 4'd0;

         // Read return pipe: the RAM answers one cycle after ram_rd, and that
         // word is registered once more, so valid, data and last all appear
         // together two cycles after the ram_rd cycle.
         rd_d1     <= ram_rd;
         last_d1   <= ram_rd && (beat_cnt == '0);
         rsp_valid <= rd_d1;
         rsp_last  <= last_d1;
         if (rd_d1) begin
            rsp_rdata <= ram_rdata;
         end

         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  we_q      <= cmd_we;
                  be_q      <= cmd_be;
                  beat_cnt  <= cmd_burst_len;
                  wait_cnt  <= WAIT_LD;
                  // ram_addr doubles as the burst address register.
                  ram_addr  <= cmd_addr;
                  ram_wdata <= cmd_wdata;
                  if (NO_WAIT) begin
                     state       <= ST_ISSUE;
                     ram_we      <= cmd_we;
                     ram_rd      <= !cmd_we;
                     ram_byte_en <= cmd_we ? cmd_be : 4'd0;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state       <= ST_ISSUE;
                  ram_we      <= we_q;
                  ram_rd      <= !we_q;
                  ram_byte_en <= we_q ? be_q : 4'd0;
               end
            end

            ST_ISSUE: begin
               if (we_q) begin
                  state     <= ST_IDLE;
                  cmd_ready <= 1'b1;
               end else if (beat_cnt == '0) begin
                  state <= ST_DRAIN;
               end else begin
                  // Address wraps naturally at the top word.
                  beat_cnt <= beat_cnt - BEAT_ONE;
                  ram_addr <= ram_addr + ADDR_ONE;
                  wait_cnt <= WAIT_LD;
                  if (NO_WAIT) begin
                     state  <= ST_ISSUE;
                     ram_rd <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end

            ST_DRAIN: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end

            default: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
